// File: rtl/irig_b_pkg.sv
// irig_b_pkg: symbol codes, frame length and FSM state encoding shared by the IRIG-B frame sync.
package irig_b_pkg;
   localparam logic [7:0] SYM_P     = 8'h70;
   localparam logic [7:0] SYM_0     = 8'h30;
   localparam logic [7:0] SYM_1     = 8'h31;
   localparam logic [7:0] SYM_IDLE  = 8'h00;
   localparam logic [6:0] FRAME_LEN = 7'd100;
   typedef enum logic [1:0] {HUNT, PREF1, LOCKED} state_t;
endpackage

// File: rtl/irig_b_sym_sampler.sv
// irig_b_sym_sampler: symbol-period timing, mid-period symbol capture and idle (loss-of-signal) detection.
//   pll_c0, rst : clock, synchronous active-high reset
//   code        : incoming 8-bit symbol code
//   s_reg       : last captured symbol
//   s_vld       : one-cycle pulse when s_reg was just captured
//   los_hit     : idle counter has reached LOS_CYC
module irig_b_sym_sampler
   import irig_b_pkg::*;
#(
   parameter logic [31:0] CNT_10MS_MAX = 32'd1_249_999,
   parameter logic [31:0] SAMPLE_AT    = 32'd624_999,
   parameter logic [31:0] LOS_CYC      = 32'd2_500_000
) (
   input  logic       pll_c0,
   input  logic       rst,
   input  logic [7:0] code,
   output logic [7:0] s_reg,
   output logic       s_vld,
   output logic       los_hit
);
   logic [31:0] cnt_q, cnt_d, idle_q, idle_d;
   logic [7:0]  s_reg_q, s_reg_d;
   logic        s_vld_q, s_vld_d, idle, samp;
   // idle input holds the period counter at 0, so symbols re-align after every gap;
   // an idle code is never captured even if it lands on the sample point
   always_comb begin
      idle    = code == SYM_IDLE;
      samp    = cnt_q == SAMPLE_AT && !idle;
      cnt_d   = idle ? '0 : (cnt_q == CNT_10MS_MAX ? '0 : cnt_q + 32'd1);
      idle_d  = !idle ? '0 : (idle_q == LOS_CYC ? idle_q : idle_q + 32'd1);
      s_vld_d = samp;
      s_reg_d = samp ? code : s_reg_q;
   end
   always_ff @(posedge pll_c0) begin
      if (rst) begin
         cnt_q   <= '0;
         idle_q  <= '0;
         s_reg_q <= '0;
         s_vld_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idle_q  <= idle_d;
         s_reg_q <= s_reg_d;
         s_vld_q <= s_vld_d;
      end
   end
   assign s_reg   = s_reg_q;
   assign s_vld   = s_vld_q;
   assign los_hit = idle_q == LOS_CYC;
endmodule

// File: rtl/irig_b_frame_sync.sv
// irig_b_frame_sync: acquires double-P frame lock, tracks symbol index 0..99 and emits decoder strobes.
//   pll_c0, rst      : clock, synchronous active-high reset
//   moni_b_code_out  : symbol code (P / '0' / '1' / idle / invalid)
//   err_clr          : clears err_cnt
//   sym_stb, sym_idx, sym_bit, bit_stb : per-symbol strobe, frame position, bit value, data-bit strobe
//   frame_start, frame_done            : accepted P at idx 0 / idx 99
//   locked, frame_err, los, err_cnt    : lock status, framing error, loss of signal, saturating error count
module irig_b_frame_sync
   import irig_b_pkg::*;
#(
   parameter logic [31:0] CNT_10MS_MAX = 32'd1_249_999,
   parameter logic [31:0] SAMPLE_AT    = 32'd624_999,
   parameter logic [31:0] LOS_CYC      = 32'd2_500_000
) (
   input  logic       pll_c0,
   input  logic       rst,
   input  logic [7:0] moni_b_code_out,
   input  logic       err_clr,
   output logic       sym_stb,
   output logic [6:0] sym_idx,
   output logic       sym_bit,
   output logic       bit_stb,
   output logic       frame_start,
   output logic       frame_done,
   output logic       locked,
   output logic       frame_err,
   output logic       los,
   output logic [7:0] err_cnt
);
   logic [7:0] s_reg, err_cnt_q, err_cnt_d;
   logic       s_vld, los_hit, is_p, is_0, is_1, exp_p, sym_ok;
   logic [6:0] idx_q, idx_d, nidx;
   state_t     state_q, state_d;
   logic       sym_stb_q, sym_stb_d, sym_bit_q, sym_bit_d, bit_stb_q, bit_stb_d;
   logic       frame_start_q, frame_start_d, frame_done_q, frame_done_d;
   logic       locked_q, locked_d, frame_err_q, frame_err_d, los_q, los_d;
   irig_b_sym_sampler #(
      .CNT_10MS_MAX(CNT_10MS_MAX),
      .SAMPLE_AT   (SAMPLE_AT),
      .LOS_CYC     (LOS_CYC)
   ) u_sampler (
      .pll_c0 (pll_c0),
      .rst    (rst),
      .code   (moni_b_code_out),
      .s_reg  (s_reg),
      .s_vld  (s_vld),
      .los_hit(los_hit)
   );
   assign is_p   = s_reg == SYM_P;
   assign is_0   = s_reg == SYM_0;
   assign is_1   = s_reg == SYM_1;
   assign nidx   = idx_q == FRAME_LEN - 7'd1 ? '0 : idx_q + 7'd1;
   // position identifiers sit at idx 0 and every idx ending in 9
   assign exp_p  = nidx == '0 || 7'(nidx % 7'd10) == 7'd9;
   assign sym_ok = exp_p ? is_p : (is_0 || is_1);
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      locked_d      = locked_q;
      sym_bit_d     = sym_bit_q;
      sym_stb_d     = 1'b0;
      bit_stb_d     = 1'b0;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;
      frame_err_d   = 1'b0;
      los_d         = 1'b0;
      if (los_hit && state_q != HUNT) begin
         los_d    = 1'b1;
         locked_d = 1'b0;
         state_d  = HUNT;
      end else if (s_vld) begin
         sym_stb_d = 1'b1;
         sym_bit_d = is_1;
         if (state_q == HUNT) begin
            state_d = is_p ? PREF1 : HUNT;
         end else if (state_q == PREF1) begin
            state_d       = is_p ? LOCKED : HUNT;
            locked_d      = is_p;
            idx_d         = is_p ? '0 : idx_q;
            frame_start_d = is_p;
         end else if (sym_ok) begin
            idx_d         = nidx;
            bit_stb_d     = !exp_p;
            frame_start_d = nidx == '0;
            frame_done_d  = nidx == FRAME_LEN - 7'd1;
         end else begin
            frame_err_d = 1'b1;
            locked_d    = 1'b0;
            state_d     = HUNT;
         end
      end
      err_cnt_d = err_clr ? '0 : (frame_err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
   end
   always_ff @(posedge pll_c0) begin
      if (rst) begin
         state_q       <= HUNT;
         idx_q         <= '0;
         err_cnt_q     <= '0;
         sym_stb_q     <= 1'b0;
         sym_bit_q     <= 1'b0;
         bit_stb_q     <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         locked_q      <= 1'b0;
         frame_err_q   <= 1'b0;
         los_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         err_cnt_q     <= err_cnt_d;
         sym_stb_q     <= sym_stb_d;
         sym_bit_q     <= sym_bit_d;
         bit_stb_q     <= bit_stb_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
         locked_q      <= locked_d;
         frame_err_q   <= frame_err_d;
         los_q         <= los_d;
      end
   end
   assign sym_stb     = sym_stb_q;
   assign sym_idx     = idx_q;
   assign sym_bit     = sym_bit_q;
   assign bit_stb     = bit_stb_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign locked      = locked_q;
   assign frame_err   = frame_err_q;
   assign los         = los_q;
   assign err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_irig_b_frame_sync.sv
// tb_irig_b_frame_sync: table-driven symbol vectors plus hand sequences for LOS, reset and error-count corners.
module tb_irig_b_frame_sync;
   localparam logic [7:0] P = 8'h70, ZERO = 8'h30, ONE = 8'h31;
   logic       pll_c0 = 1'b0, rst = 1'b1, err_clr = 1'b0;
   logic [7:0] code = 8'h00;
   logic       sym_stb, sym_bit, bit_stb, frame_start, frame_done, locked, frame_err, los;
   logic [6:0] sym_idx;
   logic [7:0] err_cnt;
   int         checks = 0, errors = 0;
   logic       o_stb, o_bs, o_sb, o_fs, o_fd, o_fe, o_lk;
   logic [6:0] o_idx;
   logic [7:0] o_err;
   typedef struct {
      logic [7:0] sym;
      logic       bs, sb, fs, fd, fe, lk;
      logic [6:0] idx;
      logic [7:0] err;
   } vec_t;
   vec_t v[$];
   irig_b_frame_sync #(
      .CNT_10MS_MAX(32'd9),
      .SAMPLE_AT   (32'd4),
      .LOS_CYC     (32'd25)
   ) dut (
      .pll_c0         (pll_c0),
      .rst            (rst),
      .moni_b_code_out(code),
      .err_clr        (err_clr),
      .sym_stb        (sym_stb),
      .sym_idx        (sym_idx),
      .sym_bit        (sym_bit),
      .bit_stb        (bit_stb),
      .frame_start    (frame_start),
      .frame_done     (frame_done),
      .locked         (locked),
      .frame_err      (frame_err),
      .los            (los),
      .err_cnt        (err_cnt)
   );
   always #5 pll_c0 = ~pll_c0;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got=%h want=%h", n, a, e);
      end
   endtask
   function automatic void add(input logic [7:0] s, input logic bs, sb, fs, fd, fe, lk,
                               input logic [6:0] idx, input logic [7:0] err);
      v.push_back('{s, bs, sb, fs, fd, fe, lk, idx, err});
   endfunction
   // one symbol = 10 clocks starting just after an edge; outputs sampled in clock 6, pulses must be gone in clock 7
   task automatic send_sym(input logic [7:0] s, input logic clr);
      code = s;
      repeat (5) @(posedge pll_c0);
      #1 err_clr = clr;
      @(posedge pll_c0);
      #1 {o_stb, o_bs, o_sb, o_fs, o_fd, o_fe, o_lk, o_idx, o_err} =
         {sym_stb, bit_stb, sym_bit, frame_start, frame_done, frame_err, locked, sym_idx, err_cnt};
      @(posedge pll_c0);
      #1 err_clr = 1'b0;
      chk("pulse_width", {26'd0, sym_stb, bit_stb, frame_start, frame_done, frame_err, los}, 32'd0);
      repeat (3) @(posedge pll_c0);
      #1;
   endtask
   initial begin
      add(8'h41, 0, 0, 0, 0, 0, 0, 7'd0, 8'd0);
      add(P,     0, 0, 0, 0, 0, 0, 7'd0, 8'd0);
      add(ZERO,  0, 0, 0, 0, 0, 0, 7'd0, 8'd0);
      add(P,     0, 0, 0, 0, 0, 0, 7'd0, 8'd0);
      add(P,     0, 0, 1, 0, 0, 1, 7'd0, 8'd0);
      for (int i = 1; i < 100; i++) begin
         logic       p;
         logic [7:0] s;
         p = (i % 10) == 9;
         s = p ? P : ((i == 1 || i == 3) ? ONE : ZERO);
         add(s, !p, s == ONE, 0, i == 99, 0, 1, 7'(i), 8'd0);
      end
      add(P, 0, 0, 1, 0, 0, 1, 7'd0, 8'd0);
      for (int i = 1; i < 29; i++) begin
         logic p;
         p = (i % 10) == 9;
         add(p ? P : ZERO, !p, 0, 0, 0, 0, 1, 7'(i), 8'd0);
      end
      add(ONE,  0, 1, 0, 0, 1, 0, 7'd28, 8'd1);
      add(P,    0, 0, 0, 0, 0, 0, 7'd28, 8'd1);
      add(P,    0, 0, 1, 0, 0, 1, 7'd0,  8'd1);
      add(ZERO, 1, 0, 0, 0, 0, 1, 7'd1,  8'd1);
      repeat (3) @(posedge pll_c0);
      #1 rst = 1'b0;
      chk("reset_outs", {17'd0, sym_stb, bit_stb, sym_bit, frame_start, frame_done, locked, frame_err, los, sym_idx},
          32'd0);
      chk("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
      foreach (v[i]) begin
         send_sym(v[i].sym, 1'b0);
         chk($sformatf("vec%0d", i), {10'd0, o_stb, o_bs, o_sb, o_fs, o_fd, o_fe, o_lk, o_idx, o_err},
             {10'd0, 1'b1, v[i].bs, v[i].sb, v[i].fs, v[i].fd, v[i].fe, v[i].lk, v[i].idx, v[i].err});
      end
      code = 8'h00;
      repeat (25) @(posedge pll_c0);
      #1 code = ZERO;
      @(posedge pll_c0);
      #1 chk("los_pulse", {29'd0, los, locked, frame_err}, {29'd0, 3'b100});
      chk("los_err_cnt", {24'd0, err_cnt}, 32'd1);
      @(posedge pll_c0);
      #1 chk("los_width", {31'd0, los}, 32'd0);
      repeat (4) @(posedge pll_c0);
      #1 chk("after_los_hunt", {29'd0, sym_stb, bit_stb, locked}, {29'd0, 3'b100});
      repeat (4) @(posedge pll_c0);
      #1;
      send_sym(P, 1'b0);
      send_sym(P, 1'b0);
      chk("relock", {31'd0, o_lk}, 32'd1);
      code = ONE;
      rst  = 1'b1;
      repeat (3) @(posedge pll_c0);
      #1 rst = 1'b0;
      chk("midrst_outs", {17'd0, sym_stb, bit_stb, sym_bit, frame_start, frame_done, locked, frame_err, los, sym_idx},
          32'd0);
      chk("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
      for (int k = 3; k <= 9; k++) begin
         chk($sformatf("midrst_stb_c%0d", k), {31'd0, sym_stb}, {31'd0, k == 9});
         if (k < 9) begin
            @(posedge pll_c0);
            #1;
         end
      end
      code = 8'h00;
      @(posedge pll_c0);
      #1;
      for (int n = 0; n < 256; n++) begin
         send_sym(P, 1'b0);
         send_sym(P, 1'b0);
         send_sym(P, 1'b0);
         if (n == 0) chk("err_first", {24'd0, o_err, o_fe}, {24'd0, 8'd1, 1'b1} >> 0);
      end
      chk("err_sat", {24'd0, err_cnt}, 32'd255);
      send_sym(P, 1'b0);
      send_sym(P, 1'b0);
      send_sym(P, 1'b1);
      chk("clr_vs_err", {23'd0, o_fe, o_err}, {23'd0, 1'b1, 8'd0});
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
